alu_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `alu` instance between `N_REQ` requesters over valid/ready handshakes. It issues at most one operation per cycle to the ALU and registers the result and flags into a per-requester response slot. The response is presented one cycle after acceptance and is held until the requester consumes it. It sits between the ALU and its clients, such as the execute stage and a multi-cycle multiply/divide sequencer.

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_if
// Brief   : Requester, response and shared-ALU signals of alu_arbiter.
// Revision: 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int N     = 32,
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*N-1:0] req_a;
    logic [N_REQ*N-1:0] req_b;
    logic [N_REQ*4-1:0] req_control;

    logic [N_REQ-1:0]   resp_valid;
    logic [N_REQ-1:0]   resp_ready;
    logic [N_REQ*N-1:0] resp_result;
    logic [N_REQ-1:0]   resp_overflow;
    logic [N_REQ-1:0]   resp_zero;
    logic [N_REQ-1:0]   resp_equal;

    logic [N-1:0]       alu_a;
    logic [N-1:0]       alu_b;
    logic [3:0]         alu_control;
    logic [N-1:0]       alu_result;
    logic               alu_overflow;
    logic               alu_zero;
    logic               alu_equal;

    // Environment side: requesters plus the shared ALU
    modport master (
        output req_valid, req_a, req_b, req_control, resp_ready,
        output alu_result, alu_overflow, alu_zero, alu_equal,
        input  req_ready, resp_valid, resp_result, resp_overflow, resp_zero, resp_equal,
        input  alu_a, alu_b, alu_control
    );

    modport slave (
        input  req_valid, req_a, req_b, req_control, resp_ready,
        input  alu_result, alu_overflow, alu_zero, alu_equal,
        output req_ready, resp_valid, resp_result, resp_overflow, resp_zero, resp_equal,
        output alu_a, alu_b, alu_control
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one combinational ALU between N_REQ
//           requesters, with a registered response slot per requester.
// Revision: 1.0
// ============================================================================
module alu_arbiter #(
    parameter int N     = 32,
    parameter int N_REQ = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int         PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int         SCAN_W  = PTR_W + 1;
    localparam logic [3:0] ALU_AND = 4'b0000;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      slot_q   [N_REQ];
    logic [N-1:0]     result_q [N_REQ];
    logic [N_REQ-1:0] ovf_q;
    logic [N_REQ-1:0] zero_q;
    logic [N_REQ-1:0] equal_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    logic [N-1:0]     w_req_a   [N_REQ];
    logic [N-1:0]     w_req_b   [N_REQ];
    logic [3:0]       w_req_ctl [N_REQ];
    logic [N_REQ-1:0] w_full;
    logic [N_REQ-1:0] w_avail;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_ready;
    logic             w_gnt_valid;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [SCAN_W-1:0] w_scan;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_slot
            assign w_req_a[i]   = bus.req_a[i*N +: N];
            assign w_req_b[i]   = bus.req_b[i*N +: N];
            assign w_req_ctl[i] = bus.req_control[i*4 +: 4];
            assign w_full[i]    = (slot_q[i] == SLOT_FULL);
            // A full slot frees up in the same cycle its owner drains it
            assign w_avail[i]   = !w_full[i] || bus.resp_ready[i];

            assign bus.resp_result[i*N +: N] = result_q[i];
        end
    endgenerate

    assign bus.resp_valid    = w_full;
    assign bus.resp_overflow = ovf_q;
    assign bus.resp_zero     = zero_q;
    assign bus.resp_equal    = equal_q;

    assign w_elig = rst_n ? (bus.req_valid & w_avail) : '0;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, ptr_q} + SCAN_W'(k);
            if (w_scan >= SCAN_W'(N_REQ)) begin
                w_scan = w_scan - SCAN_W'(N_REQ);
            end
            if (!w_gnt_valid && w_elig[w_scan[PTR_W-1:0]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_gnt_valid) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;

    assign ptr_d = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign bus.alu_a       = w_gnt_valid ? w_req_a[w_gnt_idx]   : '0;
    assign bus.alu_b       = w_gnt_valid ? w_req_b[w_gnt_idx]   : '0;
    assign bus.alu_control = w_gnt_valid ? w_req_ctl[w_gnt_idx] : ALU_AND;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            ovf_q   <= '0;
            zero_q  <= '0;
            equal_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_q[i]   <= SLOT_EMPTY;
                result_q[i] <= '0;
            end
        end else begin
            if (w_gnt_valid) begin
                ptr_q <= ptr_d;
            end
            for (int i = 0; i < N_REQ; i++) begin
                // Reload takes precedence over drain so a same-cycle pair keeps the slot full
                if (w_gnt_valid && (w_gnt_idx == PTR_W'(i))) begin
                    slot_q[i]   <= SLOT_FULL;
                    result_q[i] <= bus.alu_result;
                    ovf_q[i]    <= bus.alu_overflow;
                    zero_q[i]   <= bus.alu_zero;
                    equal_q[i]  <= bus.alu_equal;
                end else if (w_full[i] && bus.resp_ready[i]) begin
                    slot_q[i] <= SLOT_EMPTY;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Directed self-checking bench for alu_arbiter with a reference ALU.
// Revision: 1.0
// ============================================================================
module tb_alu_arbiter;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_arbiter_if #(.N(32), .N_REQ(2)) bus_if ();

    alu_arbiter #(.N(32), .N_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    logic [31:0] alu_r;
    logic        alu_v;
    always_comb begin
        alu_r = 32'h0;
        alu_v = 1'b0;
        case (bus_if.alu_control)
            ALU_AND: alu_r = bus_if.alu_a & bus_if.alu_b;
            ALU_OR:  alu_r = bus_if.alu_a | bus_if.alu_b;
            ALU_ADD: begin
                alu_r = bus_if.alu_a + bus_if.alu_b;
                alu_v = (bus_if.alu_a[31] == bus_if.alu_b[31]) && (alu_r[31] != bus_if.alu_a[31]);
            end
            ALU_SUB: begin
                alu_r = bus_if.alu_a - bus_if.alu_b;
                alu_v = (bus_if.alu_a[31] != bus_if.alu_b[31]) && (alu_r[31] != bus_if.alu_a[31]);
            end
            default: alu_r = 32'h0;
        endcase
        bus_if.alu_result   = alu_r;
        bus_if.alu_overflow = alu_v;
        bus_if.alu_zero     = (alu_r == 32'h0);
        bus_if.alu_equal    = (bus_if.alu_a == bus_if.alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] ctl,
                           input logic [31:0] a, input logic [31:0] b);
        bus_if.req_control[i*4 +: 4] = ctl;
        bus_if.req_a[i*32 +: 32]     = a;
        bus_if.req_b[i*32 +: 32]     = b;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held for two edges with every requester asking
        rst_n                = 1'b0;
        bus_if.req_valid     = 2'b11;
        bus_if.resp_ready    = 2'b00;
        bus_if.req_a         = '0;
        bus_if.req_b         = '0;
        bus_if.req_control   = '0;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_ADD, 32'd3, 32'd4);
        tick();
        mid();
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst_alu_ctl",   32'(bus_if.alu_control), 32'(ALU_AND));
        chk("rst_alu_a",     bus_if.alu_a, 32'h0);
        tick();
        chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'h0);
        chk("rst_result0",    bus_if.resp_result[31:0], 32'h0);
        chk("rst_result1",    bus_if.resp_result[63:32], 32'h0);

        rst_n             = 1'b1;
        bus_if.req_valid  = 2'b00;
        bus_if.resp_ready = 2'b11;
        tick();

        // Single ADD with signed overflow
        bus_if.req_valid = 2'b01;
        set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        mid();
        chk("add_req_ready", 32'(bus_if.req_ready), 32'h1);
        chk("add_alu_a",     bus_if.alu_a, 32'h7FFF_FFFF);
        chk("add_alu_ctl",   32'(bus_if.alu_control), 32'(ALU_ADD));
        tick();
        bus_if.req_valid = 2'b00;
        chk("add_resp_valid", 32'(bus_if.resp_valid), 32'h1);
        chk("add_result",     bus_if.resp_result[31:0], 32'h8000_0000);
        chk("add_ovf",        32'(bus_if.resp_overflow[0]), 32'h1);
        chk("add_zero",       32'(bus_if.resp_zero[0]), 32'h0);
        chk("add_equal",      32'(bus_if.resp_equal[0]), 32'h0);
        tick();
        chk("add_drained", 32'(bus_if.resp_valid), 32'h0);

        // Requester 1 alone, which moves the pointer back to 0
        bus_if.req_valid = 2'b10;
        set_req(1, ALU_AND, 32'hFF, 32'h0F);
        mid();
        chk("r1_req_ready", 32'(bus_if.req_ready), 32'h2);
        tick();
        chk("r1_result", bus_if.resp_result[63:32], 32'h0F);
        chk("r1_valid",  32'(bus_if.resp_valid), 32'h2);

        // Round-robin under contention
        bus_if.req_valid = 2'b11;
        set_req(0, ALU_SUB, 32'd5, 32'd5);
        set_req(1, ALU_AND, 32'hF0, 32'h0F);
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("rr_grant", 32'(bus_if.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("rr_valid", 32'(bus_if.resp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k % 2 == 0) begin
                chk("rr_result0", bus_if.resp_result[31:0], 32'h0);
                chk("rr_zero0",   32'(bus_if.resp_zero[0]), 32'h1);
                chk("rr_equal0",  32'(bus_if.resp_equal[0]), 32'h1);
            end else begin
                chk("rr_result1", bus_if.resp_result[63:32], 32'h0);
                chk("rr_zero1",   32'(bus_if.resp_zero[1]), 32'h1);
                chk("rr_equal1",  32'(bus_if.resp_equal[1]), 32'h0);
            end
        end

        // Back-pressure: requester 0 parks a result while requester 1 streams
        bus_if.req_valid  = 2'b01;
        bus_if.resp_ready = 2'b10;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        mid();
        chk("bp_fill_grant", 32'(bus_if.req_ready), 32'h1);
        tick();
        chk("bp_fill_result", bus_if.resp_result[31:0], 32'h1E);
        chk("bp_fill_valid",  32'(bus_if.resp_valid), 32'h1);
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        bus_if.req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_req(1, ALU_ADD, 32'd100 + 32'(k), 32'd1);
            mid();
            chk("bp_grant1", 32'(bus_if.req_ready), 32'h2);
            tick();
            chk("bp_hold0",   bus_if.resp_result[31:0], 32'h1E);
            chk("bp_valid",   32'(bus_if.resp_valid), 32'h3);
            chk("bp_result1", bus_if.resp_result[63:32], 32'd101 + 32'(k));
        end
        bus_if.resp_ready = 2'b11;
        mid();
        chk("bp_regrant0", 32'(bus_if.req_ready), 32'h1);
        tick();
        chk("bp_new0",   bus_if.resp_result[31:0], 32'h2);
        chk("bp_valid2", 32'(bus_if.resp_valid), 32'h1);

        // Consume and reload in the same cycle
        bus_if.req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            set_req(0, ALU_ADD, 32'h1000 + 32'(k), 32'h0);
            mid();
            chk("cr_grant", 32'(bus_if.req_ready), 32'h1);
            tick();
            chk("cr_valid",  32'(bus_if.resp_valid[0]), 32'h1);
            chk("cr_result", bus_if.resp_result[31:0], 32'h1000 + 32'(k));
        end

        // Fill both slots, leaving the pointer at 1
        bus_if.req_valid  = 2'b10;
        bus_if.resp_ready = 2'b00;
        set_req(1, ALU_ADD, 32'd7, 32'd7);
        mid();
        chk("fill_grant1", 32'(bus_if.req_ready), 32'h2);
        tick();
        bus_if.req_valid  = 2'b01;
        bus_if.resp_ready = 2'b01;
        set_req(0, ALU_SUB, 32'd9, 32'd4);
        mid();
        chk("fill_grant0", 32'(bus_if.req_ready), 32'h1);
        tick();
        chk("fill_valid",   32'(bus_if.resp_valid), 32'h3);
        chk("fill_result0", bus_if.resp_result[31:0], 32'h5);
        bus_if.req_valid  = 2'b11;
        bus_if.resp_ready = 2'b00;
        mid();
        chk("nogrant_ready", 32'(bus_if.req_ready), 32'h0);
        chk("nogrant_ctl",   32'(bus_if.alu_control), 32'(ALU_AND));
        chk("nogrant_b",     bus_if.alu_b, 32'h0);
        tick();
        chk("nogrant_valid",   32'(bus_if.resp_valid), 32'h3);
        chk("nogrant_result1", bus_if.resp_result[63:32], 32'hE);

        // Mid-stream reset
        rst_n             = 1'b0;
        bus_if.resp_ready = 2'b11;
        mid();
        chk("mrst_ready", 32'(bus_if.req_ready), 32'h0);
        tick();
        chk("mrst_valid",   32'(bus_if.resp_valid), 32'h0);
        chk("mrst_result0", bus_if.resp_result[31:0], 32'h0);
        chk("mrst_result1", bus_if.resp_result[63:32], 32'h0);
        rst_n = 1'b1;
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        mid();
        chk("mrst_first_grant", 32'(bus_if.req_ready), 32'h1);
        tick();
        chk("mrst_result", bus_if.resp_result[31:0], 32'h7);
        chk("mrst_valid2", 32'(bus_if.resp_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
